// File: rtl/phaselock_monitor_n.sv
// Phase-lock monitor: decodes CH fibre square-wave channels into lock/release.
// Define PHASELOCK_STICKY_FAULT_EN to latch o_brk/o_pulse_err until i_fault_clr.
`timescale 1ns/1ps
module phaselock_monitor_n #(
    parameter int CH       = 2,
    parameter int CNT_W    = 16,
    parameter int LOCK_MIN = 900,
    parameter int LOCK_MAX = 1100,
    parameter int NL_MIN   = 1800,
    parameter int NL_MAX   = 2200,
    parameter int BRK_CYC  = 10000,
    parameter int CONFIRM  = 3
) (
    input  logic                i_clk_20M,
    input  logic                i_reset,
    input  logic [CH-1:0]       i_rxd,
    input  logic [CH-1:0]       i_ch_mask,
    input  logic                i_force_lock,
    input  logic                i_fault_clr,
    output logic [CH-1:0]       o_lock_stat,
    output logic [CH-1:0]       o_brk,
    output logic [CH-1:0]       o_pulse_err,
    output logic [CH*CNT_W-1:0] o_period,
    output logic                o_lock,
    output logic                o_fault
);
    localparam int RUN_W = $clog2(CONFIRM + 1);
    localparam logic [CNT_W-1:0] C_LMIN  = CNT_W'(LOCK_MIN);
    localparam logic [CNT_W-1:0] C_LMAX  = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] C_NMIN  = CNT_W'(NL_MIN);
    localparam logic [CNT_W-1:0] C_NMAX  = CNT_W'(NL_MAX);
    localparam logic [CNT_W-1:0] C_BRK   = CNT_W'(BRK_CYC);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX   = '1;
    localparam logic [RUN_W-1:0] C_CONF  = RUN_W'(CONFIRM);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic lock_q;
    logic fault_q;

`ifndef PHASELOCK_STICKY_FAULT_EN
    logic unused_clr;
    assign unused_clr = i_fault_clr;
`endif

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic             sync1_q, sync2_q, hist_q, edge_q;
        logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d;
        logic             armed_q, armed_d;
        logic             cand_q, cand_d;
        logic [RUN_W-1:0] run_q, run_d, good_q, good_d;
        logic             stat_q, stat_d;
        logic             brk_q, brk_d;
        logic             err_q, err_d;
        logic             is_lock, is_nl;
        logic             brk_evt, bad_evt, conf_evt;

        always_ff @(posedge i_clk_20M) begin
            if (i_reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                hist_q  <= 1'b0;
                edge_q  <= 1'b0;
                cnt_q   <= '0;
                per_q   <= '0;
                armed_q <= 1'b0;
                cand_q  <= 1'b0;
                run_q   <= '0;
                good_q  <= '0;
                stat_q  <= 1'b1;
                brk_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                sync1_q <= i_rxd[k];
                sync2_q <= sync1_q;
                hist_q  <= sync2_q;
                edge_q  <= sync2_q ^ hist_q;
                cnt_q   <= cnt_d;
                per_q   <= per_d;
                armed_q <= armed_d;
                cand_q  <= cand_d;
                run_q   <= run_d;
                good_q  <= good_d;
                stat_q  <= stat_d;
                brk_q   <= brk_d;
                err_q   <= err_d;
            end
        end

        always_comb begin
            is_lock  = (cnt_q >= C_LMIN) && (cnt_q <= C_LMAX);
            is_nl    = (cnt_q >= C_NMIN) && (cnt_q <= C_NMAX);
            cnt_d    = cnt_q;
            per_d    = per_q;
            armed_d  = armed_q;
            cand_d   = cand_q;
            run_d    = run_q;
            good_d   = good_q;
            stat_d   = stat_q;
            brk_d    = brk_q;
            err_d    = err_q;
            brk_evt  = 1'b0;
            bad_evt  = 1'b0;
            conf_evt = 1'b0;
            if (edge_q) begin
                cnt_d   = C_ONE;
                per_d   = cnt_q;
                armed_d = 1'b1;
                if (armed_q) begin
                    if (is_lock || is_nl) begin
                        if (run_q != '0 && cand_q == is_lock) begin
                            if (run_q < C_CONF) run_d = run_q + RUN_ONE;
                        end else begin
                            cand_d = is_lock;
                            run_d  = RUN_ONE;
                        end
                        if (good_q < C_CONF) good_d = good_q + RUN_ONE;
                        if (run_d >= C_CONF) begin
                            conf_evt = 1'b1;
                            stat_d   = cand_d;
                        end
                    end else begin
                        bad_evt = 1'b1;
                        run_d   = '0;
                        good_d  = '0;
                    end
                end
            end else begin
                if (cnt_q != C_MAX) cnt_d = cnt_q + C_ONE;
                // Silent link: fail-safe to lock and restart qualification
                if (cnt_q == C_BRK) begin
                    brk_evt = 1'b1;
                    armed_d = 1'b0;
                    run_d   = '0;
                    good_d  = '0;
                    stat_d  = 1'b1;
                end
            end
`ifdef PHASELOCK_STICKY_FAULT_EN
            if (bad_evt) err_d = 1'b1;
            else if (i_fault_clr) err_d = 1'b0;
            if (brk_evt) brk_d = 1'b1;
            else if (i_fault_clr) brk_d = 1'b0;
`else
            if (bad_evt) err_d = 1'b1;
            else if (good_d >= C_CONF) err_d = 1'b0;
            if (brk_evt) brk_d = 1'b1;
            else if (conf_evt) brk_d = 1'b0;
`endif
        end

`ifdef PHASELOCK_STICKY_FAULT_EN
        logic unused_conf;
        assign unused_conf = conf_evt;
`endif

        assign o_lock_stat[k]               = stat_q;
        assign o_brk[k]                     = brk_q;
        assign o_pulse_err[k]               = err_q;
        assign o_period[k*CNT_W +: CNT_W]   = per_q;
    end

    always_ff @(posedge i_clk_20M) begin
        if (i_reset) begin
            lock_q  <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            lock_q  <= (|(o_lock_stat & ~i_ch_mask)) | i_force_lock;
            fault_q <= |((o_brk | o_pulse_err) & ~i_ch_mask);
        end
    end

    assign o_lock  = lock_q;
    assign o_fault = fault_q;
endmodule

// File: tb/tb_phaselock_monitor_n.sv
// Bench for phaselock_monitor_n: timestamp/interval-history model checked
// every cycle, plus literal expectations at the end of each directed phase.
`timescale 1ns/1ps
module tb_phaselock_monitor_n;
    localparam int LMIN = 900;
    localparam int LMAX = 1100;
    localparam int NMIN = 1800;
    localparam int NMAX = 2200;
    localparam int BRK  = 10000;
`ifdef PHASELOCK_STICKY_FAULT_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    wire  [1:0]  rxd;
    logic [1:0]  msk;
    logic        frc;
    logic        clr;
    logic [1:0]  o_lock_stat, o_brk, o_pulse_err;
    logic [31:0] o_period;
    logic        o_lock, o_fault;

    int half [2] = '{0, 0};
    int inj_len [2] = '{0, 0};
    int inj_cnt [2] = '{0, 0};

    int n_chk = 0;
    int n_err = 0;

    always #25 clk = ~clk;

    phaselock_monitor_n dut (
        .i_clk_20M    (clk),
        .i_reset      (rst),
        .i_rxd        (rxd),
        .i_ch_mask    (msk),
        .i_force_lock (frc),
        .i_fault_clr  (clr),
        .o_lock_stat  (o_lock_stat),
        .o_brk        (o_brk),
        .o_pulse_err  (o_pulse_err),
        .o_period     (o_period),
        .o_lock       (o_lock),
        .o_fault      (o_fault)
    );

    // Square-wave generators; a new half-period or one-shot length
    // takes effect at the next toggle.
    for (genvar g = 0; g < 2; g++) begin : g_gen
        logic rx;
        int   cnt, cur, seen;
        initial begin
            rx = 1'b0; cnt = 0; cur = 0; seen = 0;
            forever begin
                @(posedge clk); #1;
                if (cur == 0) begin
                    if (half[g] != 0) begin
                        cur = half[g];
                        cnt = 0;
                    end
                end else begin
                    cnt++;
                    if (cnt >= cur) begin
                        rx  = ~rx;
                        cnt = 0;
                        if (inj_cnt[g] != seen) begin
                            cur  = inj_len[g];
                            seen = inj_cnt[g];
                        end else begin
                            cur = half[g];
                        end
                    end
                end
            end
        end
        assign rxd[g] = rx;
    end

    // Model: edges seen 3 samples late, H = cycles since last edge,
    // decisions taken from the last three interval classes.
    int unsigned ncyc = 0;
    bit [4:0]    smp [2];
    int unsigned last [2];
    int          hs [2][3];
    int          nh [2];
    logic [15:0] per_m [2];
    bit   [1:0]  stat_m, brk_m, err_m, armed_m;
    bit          lock_m, fault_m;

    task automatic model_step();
        bit          bad, brk_ev, conf, allgood, ev;
        int unsigned h;
        int          cl;
        ncyc++;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                smp[c]   = '0;
                last[c]  = ncyc + 1;
                nh[c]    = 0;
                per_m[c] = '0;
            end
            stat_m  = 2'b11;
            brk_m   = 2'b00;
            err_m   = 2'b00;
            armed_m = 2'b00;
            lock_m  = 1'b1;
            fault_m = 1'b0;
        end else begin
            lock_m  = frc || ((stat_m & ~msk) != 2'b00);
            fault_m = (((brk_m | err_m) & ~msk) != 2'b00);
            for (int c = 0; c < 2; c++) begin
                bad = 0; brk_ev = 0; conf = 0; allgood = 0;
                smp[c] = {smp[c][3:0], rxd[c]};
                ev = smp[c][3] ^ smp[c][4];
                h = ncyc - last[c];
                if (h > 65535) h = 65535;
                if (ev) begin
                    per_m[c] = 16'(h);
                    last[c]  = ncyc;
                    if (armed_m[c]) begin
                        if (h >= LMIN && h <= LMAX) cl = 1;
                        else if (h >= NMIN && h <= NMAX) cl = 0;
                        else cl = 2;
                        hs[c][2] = hs[c][1];
                        hs[c][1] = hs[c][0];
                        hs[c][0] = cl;
                        if (nh[c] < 3) nh[c]++;
                        bad = (cl == 2);
                        allgood = (nh[c] == 3) && hs[c][0] != 2 &&
                                  hs[c][1] != 2 && hs[c][2] != 2;
                        if (allgood && hs[c][0] == hs[c][1] &&
                            hs[c][1] == hs[c][2]) begin
                            conf = 1;
                            stat_m[c] = (cl == 1);
                        end
                    end
                    armed_m[c] = 1'b1;
                end else if (h == BRK) begin
                    brk_ev     = 1;
                    armed_m[c] = 1'b0;
                    nh[c]      = 0;
                    stat_m[c]  = 1'b1;
                end
                if (STICKY) begin
                    if (bad) err_m[c] = 1'b1;
                    else if (clr) err_m[c] = 1'b0;
                    if (brk_ev) brk_m[c] = 1'b1;
                    else if (clr) brk_m[c] = 1'b0;
                end else begin
                    if (bad) err_m[c] = 1'b1;
                    else if (allgood) err_m[c] = 1'b0;
                    if (brk_ev) brk_m[c] = 1'b1;
                    else if (conf) brk_m[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic cmp();
        logic [39:0] got, exp;
        got = {o_lock_stat, o_brk, o_pulse_err, o_period, o_lock, o_fault};
        exp = {stat_m, brk_m, err_m, per_m[1], per_m[0], lock_m, fault_m};
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL model cyc %0d: got %h expected %h", ncyc, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cmp();
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " stat"},  32'(o_lock_stat), 32'h3);
        chk({nm, " brk"},   32'(o_brk),       32'h0);
        chk({nm, " err"},   32'(o_pulse_err), 32'h0);
        chk({nm, " per"},   o_period,         32'h0);
        chk({nm, " lock"},  32'(o_lock),      32'h1);
        chk({nm, " fault"}, 32'(o_fault),     32'h0);
    endtask

    initial begin
        rst = 1'b1; msk = 2'b00; frc = 1'b0; clr = 1'b0;
        run(3);
        chk_reset("reset");
        rst = 1'b0;

        half[0] = 2000; half[1] = 2000;
        run(9000);
        chk("nl stat",  32'(o_lock_stat), 32'h0);
        chk("nl lock",  32'(o_lock),      32'h0);
        chk("nl per0",  32'(o_period[15:0]),  32'd2000);
        chk("nl per1",  32'(o_period[31:16]), 32'd2000);

        half[0] = 1000;
        run(6000);
        chk("lk stat",  32'(o_lock_stat), 32'h1);
        chk("lk lock",  32'(o_lock),      32'h1);
        chk("lk per0",  32'(o_period[15:0]), 32'd1000);

        half[1] = 0;
        run(12500);
        chk("brk flag",  32'(o_brk),       32'h2);
        chk("brk stat",  32'(o_lock_stat), 32'h3);
        chk("brk fault", 32'(o_fault),     32'h1);

        msk = 2'b10;
        run(3);
        chk("mask fault", 32'(o_fault), 32'h0);
        chk("mask lock1", 32'(o_lock),  32'h1);
        half[0] = 2000;
        run(8100);
        chk("mask stat",  32'(o_lock_stat), 32'h2);
        chk("mask lock0", 32'(o_lock),      32'h0);
        frc = 1'b1;
        run(3);
        chk("force lock", 32'(o_lock), 32'h1);
        frc = 1'b0;

        msk = 2'b00;
        half[1] = 2000;
        run(8500);
        chk("resume stat",  32'(o_lock_stat), 32'h0);
        chk("resume brk",   32'(o_brk),   STICKY ? 32'h2 : 32'h0);
        chk("resume fault", 32'(o_fault), STICKY ? 32'h1 : 32'h0);
        chk("resume lock",  32'(o_lock),  32'h0);

        inj_len[0] = 1500;
        inj_cnt[0] = inj_cnt[0] + 1;
        run(3600);
        chk("bad err",  32'(o_pulse_err), 32'h1);
        chk("bad stat", 32'(o_lock_stat), 32'h0);
        run(6100);
        chk("good err",   32'(o_pulse_err), STICKY ? 32'h1 : 32'h0);
        chk("good fault", 32'(o_fault),     STICKY ? 32'h1 : 32'h0);
        clr = 1'b1;
        run(1);
        clr = 1'b0;
        run(3);
        chk("clr err",   32'(o_pulse_err), 32'h0);
        chk("clr brk",   32'(o_brk),       32'h0);
        chk("clr fault", 32'(o_fault),     32'h0);

        run(500);
        rst = 1'b1;
        run(1);
        chk_reset("midrst");
        rst = 1'b0;
        run(8600);
        chk("post stat", 32'(o_lock_stat), 32'h0);
        chk("post lock", 32'(o_lock),      32'h0);
        chk("post per0", 32'(o_period[15:0]),  32'd2000);
        chk("post per1", 32'(o_period[31:16]), 32'd2000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
